// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and defaults for the falling-character scheduler
package game_pkg;

  localparam int NUM_SLOTS_D = 16;
  localparam int SLOT_W_D    = 4;
  localparam int BOTTOM_D    = 480;
  localparam int MAX_MISS_D  = 8;

  typedef struct packed {
    logic       active;
    logic [7:0] chr;
    logic [9:0] col;
    logic [9:0] row;
    logic [2:0] speed;
  } slot_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MOVE,
    ST_SEARCH,
    ST_COMMIT
  } state_t;

endpackage

// File: rtl/char_slot_sched_if.sv
// rtl/char_slot_sched_if.sv - spawn, key, render-read and status bundle
interface char_slot_sched_if #(
  parameter int SLOT_W = 4
);
  logic              spawn_valid;
  logic              spawn_ready;
  logic [7:0]        spawn_char;
  logic [9:0]        spawn_col;
  logic [2:0]        spawn_speed;
  logic              move_tick;
  logic              key_valid;
  logic [7:0]        key_code;
  logic [SLOT_W-1:0] rd_idx;
  logic              rd_active;
  logic [7:0]        rd_char;
  logic [9:0]        rd_col;
  logic [9:0]        rd_row;
  logic              hit_pulse;
  logic              miss_pulse;
  logic              key_drop;
  logic [7:0]        score;
  logic [3:0]        miss_cnt;
  logic              gameover;

  modport master (
    output spawn_valid, spawn_char, spawn_col, spawn_speed, move_tick,
           key_valid, key_code, rd_idx,
    input  spawn_ready, rd_active, rd_char, rd_col, rd_row,
           hit_pulse, miss_pulse, key_drop, score, miss_cnt, gameover
  );

  modport slave (
    input  spawn_valid, spawn_char, spawn_col, spawn_speed, move_tick,
           key_valid, key_code, rd_idx,
    output spawn_ready, rd_active, rd_char, rd_col, rd_row,
           hit_pulse, miss_pulse, key_drop, score, miss_cnt, gameover
  );
endinterface

// File: rtl/slot_find_free.sv
// rtl/slot_find_free.sv - lowest-index inactive slot, with a none-free flag
module slot_find_free #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic [N-1:0] active_vec,
  output logic [W-1:0] free_idx,
  output logic         none
);

  // Scanning downward lets the lowest free index overwrite any higher one.
  always_comb begin
    free_idx = '0;
    none     = 1'b1;
    for (int i = N - 1; i >= 0; i--) begin
      if (!active_vec[i]) begin
        free_idx = W'(i);
        none     = 1'b0;
      end
    end
  end

endmodule

// File: rtl/char_slot_sched.sv
// rtl/char_slot_sched.sv - slot table owner sequencing spawn, move sweep and key hit
module char_slot_sched
  import game_pkg::*;
#(
  parameter int NUM_SLOTS = NUM_SLOTS_D,
  parameter int SLOT_W    = SLOT_W_D,
  parameter int BOTTOM    = BOTTOM_D,
  parameter int MAX_MISS  = MAX_MISS_D
) (
  input logic               VGA_CLK,
  input logic               resetn,
  char_slot_sched_if.slave  bus
);

  slot_t              slots [NUM_SLOTS];
  state_t             state_q, state_d;
  logic [SLOT_W-1:0]  idx_q, best_q, free_idx;
  logic [9:0]         best_row_q;
  logic [7:0]         key_q;
  logic               found_q, tick_pend, key_pend, armed, none_free;
  logic [NUM_SLOTS-1:0] active_vec;

  slot_t       cur;
  logic [10:0] new_row;
  logic        at_bottom, take, last, spawn_fire;
  logic [3:0]  miss_inc;

  always_comb begin
    active_vec = '0;
    for (int i = 0; i < NUM_SLOTS; i++) active_vec[i] = slots[i].active;
  end

  slot_find_free #(.N(NUM_SLOTS), .W(SLOT_W)) u_find (
    .active_vec (active_vec),
    .free_idx   (free_idx),
    .none       (none_free)
  );

  assign cur       = slots[idx_q];
  assign new_row   = {1'b0, cur.row} + {8'b0, cur.speed};
  assign at_bottom = new_row >= 11'(BOTTOM);
  // Strict compare keeps the earlier (lower-index) slot on equal rows.
  assign take      = cur.active && (cur.chr == key_q) && (!found_q || cur.row > best_row_q);
  assign last      = idx_q == SLOT_W'(NUM_SLOTS - 1);
  assign miss_inc  = (bus.miss_cnt == 4'hF) ? bus.miss_cnt : bus.miss_cnt + 4'd1;

  assign bus.spawn_ready = armed && (state_q == ST_IDLE) && !tick_pend && !key_pend &&
                           !none_free && !bus.gameover;
  assign spawn_fire      = bus.spawn_valid && bus.spawn_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (!bus.gameover) begin
                   if (tick_pend)     state_d = ST_MOVE;
                   else if (key_pend) state_d = ST_SEARCH;
                 end
      ST_MOVE:   if (last) state_d = ST_IDLE;
      ST_SEARCH: if (last) state_d = (found_q || take) ? ST_COMMIT : ST_IDLE;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge VGA_CLK or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge VGA_CLK or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_SLOTS; i++) slots[i] <= '0;
      idx_q <= '0; best_q <= '0; best_row_q <= '0; key_q <= '0;
      found_q <= 1'b0; tick_pend <= 1'b0; key_pend <= 1'b0; armed <= 1'b0;
      bus.rd_active <= 1'b0; bus.rd_char <= '0; bus.rd_col <= '0; bus.rd_row <= '0;
      bus.hit_pulse <= 1'b0; bus.miss_pulse <= 1'b0; bus.key_drop <= 1'b0;
      bus.score <= '0; bus.miss_cnt <= '0; bus.gameover <= 1'b0;
    end else begin
      armed          <= 1'b1;
      bus.hit_pulse  <= 1'b0;
      bus.miss_pulse <= 1'b0;
      bus.key_drop   <= 1'b0;

      bus.rd_active <= slots[bus.rd_idx].active;
      bus.rd_char   <= slots[bus.rd_idx].chr;
      bus.rd_col    <= slots[bus.rd_idx].col;
      bus.rd_row    <= slots[bus.rd_idx].row;

      // A tick landing on the dispatch edge re-arms, so no tick is lost.
      if (bus.gameover)                          tick_pend <= 1'b0;
      else if (bus.move_tick)                    tick_pend <= 1'b1;
      else if (state_q == ST_IDLE && tick_pend)  tick_pend <= 1'b0;

      if (bus.gameover) begin
        key_pend <= 1'b0;
      end else if (bus.key_valid) begin
        if (key_pend) begin
          bus.key_drop <= 1'b1;
        end else begin
          key_pend <= 1'b1;
          key_q    <= bus.key_code;
        end
      end

      if (spawn_fire)
        slots[free_idx] <= '{active: 1'b1, chr: bus.spawn_char, col: bus.spawn_col,
                              row: 10'd0, speed: bus.spawn_speed};

      case (state_q)
        ST_IDLE: begin
          idx_q   <= '0;
          found_q <= 1'b0;
        end
        ST_MOVE: begin
          idx_q <= idx_q + SLOT_W'(1);
          if (cur.active) begin
            if (at_bottom) begin
              slots[idx_q]   <= '0;
              bus.miss_pulse <= 1'b1;
              bus.miss_cnt   <= miss_inc;
              if (miss_inc >= 4'(MAX_MISS)) bus.gameover <= 1'b1;
            end else begin
              slots[idx_q].row <= new_row[9:0];
            end
          end
        end
        ST_SEARCH: begin
          idx_q <= idx_q + SLOT_W'(1);
          if (take) begin
            found_q    <= 1'b1;
            best_q     <= idx_q;
            best_row_q <= cur.row;
          end
          if (last && !(found_q || take)) begin
            key_pend     <= 1'b0;
            bus.key_drop <= 1'b1;
          end
        end
        ST_COMMIT: begin
          slots[best_q] <= '0;
          bus.hit_pulse <= 1'b1;
          bus.score     <= (bus.score == 8'hFF) ? bus.score : bus.score + 8'd1;
          key_pend      <= 1'b0;
          found_q       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
